// File: rtl/dm_order_checker.sv
// Data-memory read-back checker: streams count words from base_addr and reports
// whether every adjacent pair is non-decreasing, plus the first offending index.
module dm_order_checker #(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] count,
  output logic        mem_re,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        sorted,
  output logic [15:0] fail_index
);

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] iss_q;     // index of the next read to issue
  logic [CW-1:0] rcv_q;     // index of the word returning this cycle
  logic          rv_q;      // mem_rdata carries a word this cycle
  logic [31:0]   prev_q;
  logic          mem_re_q;
  logic [AW-1:0] mem_addr_q;
  logic          busy_q;
  logic          done_q;
  logic          sorted_q;
  logic [CW-1:0] fail_q;
  logic          viol_c;

  // Pair violation: previous word strictly greater than the returning word.
  always_comb begin
    viol_c = 1'b0;
    if (SIGNED) viol_c = $signed(prev_q) > $signed(mem_rdata);
    else        viol_c = prev_q > mem_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      iss_q      <= '0;
      rcv_q      <= '0;
      rv_q       <= 1'b0;
      prev_q     <= '0;
      mem_re_q   <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sorted_q   <= 1'b0;
      fail_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cnt_q    <= count;
            sorted_q <= 1'b0;
            fail_q   <= '0;
            rv_q     <= 1'b0;
            rcv_q    <= '0;
            if (count >= CW'(2)) begin
              state_q    <= ST_SCAN;
              busy_q     <= 1'b1;
              mem_re_q   <= 1'b1;
              mem_addr_q <= base_addr & ~AW'(3);
              iss_q      <= CW'(1);
            end else begin
              state_q  <= ST_FINISH;
              done_q   <= 1'b1;
              sorted_q <= 1'b1;
            end
          end
        end

        ST_SCAN: begin
          rv_q <= mem_re_q;
          if (iss_q < cnt_q) begin
            mem_re_q   <= 1'b1;
            mem_addr_q <= mem_addr_q + AW'(4);
            iss_q      <= iss_q + CW'(1);
          end else begin
            mem_re_q <= 1'b0;
          end
          // Later assignments here override the issue logic above on termination.
          if (rv_q) begin
            prev_q <= mem_rdata;
            rcv_q  <= rcv_q + CW'(1);
            if ((rcv_q != '0) && viol_c) begin
              state_q  <= ST_FINISH;
              fail_q   <= rcv_q;
              sorted_q <= 1'b0;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              mem_re_q <= 1'b0;
              rv_q     <= 1'b0;
            end else if (rcv_q == cnt_q - CW'(1)) begin
              state_q  <= ST_FINISH;
              fail_q   <= '0;
              sorted_q <= 1'b1;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              mem_re_q <= 1'b0;
              rv_q     <= 1'b0;
            end
          end
        end

        ST_FINISH: begin
          state_q <= ST_IDLE;
          rv_q    <= 1'b0;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_re     = mem_re_q;
  assign mem_addr   = mem_addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sorted     = sorted_q;
  assign fail_index = fail_q;

endmodule

// File: tb/tb_dm_order_checker.sv
// Scoreboard bench for dm_order_checker: a signed and an unsigned instance share
// one memory model; stimulus queues expected reads/results, a monitor checks them.
module tb_dm_order_checker;

  typedef struct {
    int unsigned cyc;
    logic [31:0] addr;
  } rd_t;

  typedef struct {
    int unsigned cyc;
    logic        srt;
    logic [15:0] fidx;
  } dn_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [31:0]       base_addr = '0;
  logic [15:0]       count = '0;
  logic [1:0]        mem_re, busy, done, sorted;
  logic [1:0][31:0]  mem_addr;
  logic [1:0][31:0]  mem_rdata = '0;
  logic [1:0][15:0]  fail_index;

  logic [31:0] mem [logic [29:0]];
  rd_t rdq [2][$];
  dn_t dq  [2][$];
  int unsigned bl [2] = '{1, 1};
  int unsigned bh [2] = '{0, 0};
  int unsigned cyc = 0;
  int errors = 0;
  int checks = 0;

  dm_order_checker #(.SIGNED(1'b1)) u_s (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .mem_re(mem_re[0]), .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0]),
    .busy(busy[0]), .done(done[0]), .sorted(sorted[0]), .fail_index(fail_index[0])
  );

  dm_order_checker #(.SIGNED(1'b0)) u_u (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .mem_re(mem_re[1]), .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1]),
    .busy(busy[1]), .done(done[1]), .sorted(sorted[1]), .fail_index(fail_index[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rd(input logic [31:0] a);
    logic [29:0] w;
    w = 30'(a >> 2);
    return mem.exists(w) ? mem[w] : 32'd0;
  endfunction

  // Memory returns data one cycle after mem_re; junk otherwise.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      mem_rdata[i] <= mem_re[i] ? rd(mem_addr[i]) : 32'hDEADBEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
    end
  endtask

  // Monitor: checks busy every cycle and pops expectations on every read and done.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        rd_t r;
        dn_t d;
        chk($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(cyc >= bl[i] && cyc <= bh[i]));
        if (mem_re[i]) begin
          if (rdq[i].size() == 0) chk($sformatf("unexpected_read[%0d]", i), 32'(mem_re[i]), 32'd0);
          else begin
            r = rdq[i].pop_front();
            chk($sformatf("read_cycle[%0d]", i), cyc, r.cyc);
            chk($sformatf("read_addr[%0d]", i), mem_addr[i], r.addr);
          end
        end
        if (done[i]) begin
          if (dq[i].size() == 0) chk($sformatf("unexpected_done[%0d]", i), 32'(done[i]), 32'd0);
          else begin
            d = dq[i].pop_front();
            chk($sformatf("done_cycle[%0d]", i), cyc, d.cyc);
            chk($sformatf("sorted[%0d]", i), 32'(sorted[i]), 32'(d.srt));
            chk($sformatf("fail_index[%0d]", i), 32'(fail_index[i]), 32'(d.fidx));
          end
        end
      end
    end
  end

  task automatic load(input logic [31:0] b, input logic [31:0] v [12], input int n);
    for (int k = 0; k < n; k++) mem[30'(b >> 2) + 30'(k)] = v[k];
  endtask

  // Issue a start and queue the expected reads, busy window and result per instance.
  task automatic issue(input logic [31:0] b, input logic [15:0] n,
                       input logic s0, input logic [15:0] f0,
                       input logic s1, input logic [15:0] f1);
    int unsigned c, dn, nr;
    logic srt;
    logic [15:0] fi;
    logic [31:0] a;
    rd_t r;
    dn_t d;
    @(negedge clk);
    c = cyc;
    start = 1'b1;
    base_addr = b;
    count = n;
    for (int i = 0; i < 2; i++) begin
      srt = (i == 0) ? s0 : s1;
      fi  = (i == 0) ? f0 : f1;
      if (n < 16'd2) begin dn = 1; nr = 0; end
      else if (srt) begin dn = 32'(n) + 2; nr = 32'(n); end
      else begin dn = 32'(fi) + 3; nr = 32'(fi) + 2; end
      for (int k = 0; k < int'(nr); k++) begin
        a = (b & 32'hFFFFFFFC) + 32'(4 * k);
        r.cyc = c + 32'(k) + 1;
        r.addr = a;
        rdq[i].push_back(r);
      end
      d.cyc = c + dn;
      d.srt = srt;
      d.fidx = fi;
      dq[i].push_back(d);
      bl[i] = c + 1;
      bh[i] = c + dn - 1;
    end
    @(negedge clk);
    #1;
    start = 1'b0;
    if (n >= 16'd2) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("sorted_clear[%0d]", i), 32'(sorted[i]), 32'd0);
        chk($sformatf("fail_clear[%0d]", i), 32'(fail_index[i]), 32'd0);
      end
    end
  endtask

  // Returns just after the negedge of the last expected done cycle.
  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      #1;
      if (dq[0].size() == 0 && dq[1].size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("done_timeout", 32'(dq[0].size() + dq[1].size()), 32'd0);
      dq[0].delete();
      dq[1].delete();
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reads_left[%0d]", i), 32'(rdq[i].size()), 32'd0);
      rdq[i].delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] srt_a [12];
    logic [31:0] uns_a [12];
    logic [31:0] sgn_a [12];
    logic [31:0] wrp_a [12];
    srt_a = '{0, 11, 22, 33, 44, 55, 66, 77, 88, 99, 110, 121};
    uns_a = '{55, 88, 0, 22, 33, 44, 66, 77, 99, 100, 101, 102};
    sgn_a = '{32'hFFFFFFFF, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0};
    wrp_a = '{1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_mem_re[%0d]", i), 32'(mem_re[i]), 32'd0);
      chk($sformatf("rst_mem_addr[%0d]", i), mem_addr[i], 32'd0);
      chk($sformatf("rst_busy[%0d]", i), 32'(busy[i]), 32'd0);
      chk($sformatf("rst_done[%0d]", i), 32'(done[i]), 32'd0);
      chk($sformatf("rst_sorted[%0d]", i), 32'(sorted[i]), 32'd0);
      chk($sformatf("rst_fail[%0d]", i), 32'(fail_index[i]), 32'd0);
    end
    #2 reset = 1'b0;

    // Sorted scan with a start during busy and another in the done cycle, both ignored.
    load(32'd512, srt_a, 12);
    issue(32'd512, 16'd12, 1'b1, 16'd0, 1'b1, 16'd0);
    repeat (4) @(negedge clk);
    start = 1'b1; base_addr = 32'd0; count = 16'd2;
    @(negedge clk);
    #1 start = 1'b0;
    wait_done();
    start = 1'b1; base_addr = 32'd0; count = 16'd3;

    // Unsorted: violation at index 2, in-flight read of 524 discarded.
    load(32'd512, uns_a, 12);
    issue(32'd512, 16'd12, 1'b0, 16'd2, 1'b0, 16'd2);
    wait_done();

    issue(32'd0, 16'd0, 1'b1, 16'd0, 1'b1, 16'd0);
    wait_done();
    issue(32'd64, 16'd1, 1'b1, 16'd0, 1'b1, 16'd0);
    wait_done();

    // Signed vs unsigned compare with duplicates.
    load(32'd1024, sgn_a, 4);
    issue(32'd1024, 16'd4, 1'b1, 16'd0, 1'b0, 16'd1);
    wait_done();

    // Address wrap modulo 2^32; low address bits ignored.
    load(32'hFFFFFFF8, wrp_a, 3);
    issue(32'hFFFFFFF8, 16'd3, 1'b1, 16'd0, 1'b1, 16'd0);
    wait_done();
    issue(32'hFFFFFFFB, 16'd3, 1'b1, 16'd0, 1'b1, 16'd0);
    wait_done();

    // Asynchronous reset in cycle 6 of a 12-element scan.
    load(32'd512, srt_a, 12);
    issue(32'd512, 16'd12, 1'b1, 16'd0, 1'b1, 16'd0);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("abort_mem_re[%0d]", i), 32'(mem_re[i]), 32'd0);
      chk($sformatf("abort_busy[%0d]", i), 32'(busy[i]), 32'd0);
      chk($sformatf("abort_done[%0d]", i), 32'(done[i]), 32'd0);
      chk($sformatf("abort_sorted[%0d]", i), 32'(sorted[i]), 32'd0);
      dq[i].delete();
      rdq[i].delete();
      bh[i] = 0;
    end
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    issue(32'd512, 16'd12, 1'b1, 16'd0, 1'b1, 16'd0);
    wait_done();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
